// File: rtl/xillybus_user_stream_endpoint_if.sv
// Host-side stream handshake bundle: the write-file and read-file signal groups.
// Combinational wiring only; no latency of its own.
// The full/empty flags carry backpressure from the endpoint to the host.
// Ports (master = host side, slave = endpoint side):
//   user_w_write_32_{wren,data,open} host->endpoint, user_w_write_32_full endpoint->host
//   user_r_read_32_{rden,open} host->endpoint, user_r_read_32_{data,empty,eof} endpoint->host
interface xillybus_user_stream_endpoint_if;
  logic        user_w_write_32_wren;
  logic [31:0] user_w_write_32_data;
  logic        user_w_write_32_full;
  logic        user_w_write_32_open;
  logic        user_r_read_32_rden;
  logic [31:0] user_r_read_32_data;
  logic        user_r_read_32_empty;
  logic        user_r_read_32_eof;
  logic        user_r_read_32_open;

  modport master (
    output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    output user_r_read_32_rden, user_r_read_32_open,
    input  user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty,
    input  user_r_read_32_eof
  );

  modport slave (
    input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    input  user_r_read_32_rden, user_r_read_32_open,
    output user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty,
    output user_r_read_32_eof
  );
endinterface

// File: rtl/xillybus_user_stream_endpoint.sv
// Single-session loopback stream FIFO between a host write file and a host read file.
// Latency: a written word is readable one cycle after acceptance; read data is registered (1 cycle).
// Backpressure: full while not streaming or at depth (excess words dropped, overflow sticky); empty gates reads.
// Ports: bus_clk, bus_rst (sync, active high), host (slave modport of the stream interface),
//   fifo_level (current word count), overflow (sticky drop flag).
// Optional build macro XILLYBUS_STREAM_CHECKSUM_EN appends a 32-bit wrapping-sum trailer word.
module xillybus_user_stream_endpoint #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst,
  xillybus_user_stream_endpoint_if.slave host,
  output logic [DEPTH_LOG2:0]           fifo_level,
  output logic                          overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = DEPTH[DEPTH_LOG2:0];

`ifdef XILLYBUS_STREAM_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, STREAM = 3'd1, DRAIN = 3'd2, CSUM = 3'd3, DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, STREAM = 3'd1, DRAIN = 3'd2, DONE = 3'd4
  } state_t;
`endif

  state_t                  state, state_nxt;
  logic [31:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [31:0]             rd_data;
  logic                    full, empty;
  logic                    wr_acc, rd_acc, fifo_rd;
  logic                    start_evt, enter_idle;

  // Handshake qualification. fifo_rd separates a real FIFO pop from the
  // trailer read, which is accepted at level 0 and must not touch the pointers.
  always_comb begin
    full   = (state != STREAM) || (fifo_level == LEVEL_FULL);
    empty  = (fifo_level == '0);
`ifdef XILLYBUS_STREAM_CHECKSUM_EN
    if (state == CSUM) empty = 1'b0;
`endif
    wr_acc  = host.user_w_write_32_wren && !full;
    rd_acc  = host.user_r_read_32_rden && !empty;
    fifo_rd = rd_acc;
`ifdef XILLYBUS_STREAM_CHECKSUM_EN
    if (state == CSUM) fifo_rd = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (host.user_w_write_32_open) state_nxt = STREAM;
      STREAM: if (!host.user_w_write_32_open) state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_level == '0 && !wr_acc) begin
`ifdef XILLYBUS_STREAM_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef XILLYBUS_STREAM_CHECKSUM_EN
      CSUM:   if (rd_acc) state_nxt = DONE;
`endif
      DONE:   if (!host.user_r_read_32_open) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start_evt  = (state == IDLE) && (state_nxt == STREAM);
  assign enter_idle = (state != IDLE) && (state_nxt == IDLE);

`ifdef XILLYBUS_STREAM_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      csum <= '0;
    end else if (start_evt) begin
      csum <= '0;
    end else if (wr_acc) begin
      csum <= csum + host.user_w_write_32_data;
    end
  end
`endif

  // Storage array carries no reset; the pointers and level define validity.
  always_ff @(posedge bus_clk) begin
    if (wr_acc) mem[wr_ptr] <= host.user_w_write_32_data;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rd_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enter_idle) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (wr_acc)  wr_ptr <= wr_ptr + 1'b1;
        if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_acc, fifo_rd})
          2'b10:   fifo_level <= fifo_level + 1'b1;
          2'b01:   fifo_level <= fifo_level - 1'b1;
          default: fifo_level <= fifo_level;
        endcase
      end
      if (fifo_rd) begin
        rd_data <= mem[rd_ptr];
      end
`ifdef XILLYBUS_STREAM_CHECKSUM_EN
      else if (rd_acc) begin
        rd_data <= csum;
      end
`endif
      // A new session starts with a clean overflow flag.
      if (start_evt) begin
        overflow <= 1'b0;
      end else if (host.user_w_write_32_wren && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign host.user_w_write_32_full = full;
  assign host.user_r_read_32_empty = empty;
  assign host.user_r_read_32_data  = rd_data;
  assign host.user_r_read_32_eof   = (state == DONE);

endmodule

// File: tb/tb_xillybus_user_stream_endpoint.sv
// Bench for the stream endpoint: directed scenarios plus randomized sessions,
// every cycle compared against a queue-based transaction model.
module tb_xillybus_user_stream_endpoint;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef XILLYBUS_STREAM_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_STREAM = 1, PH_DRAIN = 2, PH_TRAILER = 3, PH_DONE = 4;

  logic                 bus_clk = 1'b0;
  logic                 bus_rst = 1'b0;
  logic [DEPTH_LOG2:0]  fifo_level;
  logic                 overflow;

  xillybus_user_stream_endpoint_if host ();

  xillybus_user_stream_endpoint #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .bus_clk    (bus_clk),
    .bus_rst    (bus_rst),
    .host       (host),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: words in flight, session phase, last read word, sum, overflow.
  logic [31:0] q [$];
  int          ph;
  logic [31:0] m_data;
  logic [31:0] m_sum;
  bit          m_ovf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk_eq("full",  host.user_w_write_32_full, (ph != PH_STREAM) || (q.size() == DEPTH));
    chk_eq("empty", host.user_r_read_32_empty, (ph == PH_TRAILER) ? 1'b0 : (q.size() == 0));
    chk_eq("eof",   host.user_r_read_32_eof, ph == PH_DONE);
    chk_eq("level", fifo_level, q.size());
    chk_eq("ovf",   overflow, m_ovf);
    chk_eq("data",  host.user_r_read_32_data, m_data);
  endtask

  task automatic do_reset();
    bus_rst = 1'b1;
    host.user_w_write_32_wren = 1'b0;
    host.user_r_read_32_rden  = 1'b0;
    @(posedge bus_clk);
    #1;
    bus_rst = 1'b0;
    q.delete();
    ph = PH_IDLE;
    m_data = '0;
    m_sum = '0;
    m_ovf = 1'b0;
    check_outputs();
  endtask

  task automatic step(input bit wren, input logic [31:0] wd, input bit rden,
                      input bit wo, input bit ro);
    bit full_m, empty_m, wa, ra;
    int pre_sz;
    host.user_w_write_32_wren = wren;
    host.user_w_write_32_data = wd;
    host.user_r_read_32_rden  = rden;
    host.user_w_write_32_open = wo;
    host.user_r_read_32_open  = ro;
    pre_sz  = q.size();
    full_m  = (ph != PH_STREAM) || (pre_sz == DEPTH);
    empty_m = (ph == PH_TRAILER) ? 1'b0 : (pre_sz == 0);
    wa = wren && !full_m;
    ra = rden && !empty_m;
    @(posedge bus_clk);
    if (wren && full_m) m_ovf = 1'b1;
    if (ra) m_data = (ph == PH_TRAILER) ? m_sum : q.pop_front();
    if (wa) begin
      q.push_back(wd);
      m_sum = m_sum + wd;
    end
    case (ph)
      PH_IDLE:    if (wo) begin ph = PH_STREAM; m_ovf = 1'b0; m_sum = '0; end
      PH_STREAM:  if (!wo) ph = PH_DRAIN;
      PH_DRAIN:   if (pre_sz == 0) ph = CSUM_EN ? PH_TRAILER : PH_DONE;
      PH_TRAILER: if (ra) ph = PH_DONE;
      PH_DONE:    if (!ro) begin ph = PH_IDLE; q.delete(); end
      default:    ph = PH_IDLE;
    endcase
    #1;
    check_outputs();
  endtask

  // Close the write side, read out everything (and any trailer), then close the read side.
  task automatic finish_session(input int rd_pct, input int wr_pct);
    int k = 0;
    while (ph != PH_DONE && k < 64) begin
      step(($urandom_range(0, 99) < wr_pct), $urandom, ($urandom_range(0, 99) < rd_pct), 1'b0, 1'b1);
      k++;
    end
    chk_eq("drain_eof", host.user_r_read_32_eof, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    host.user_w_write_32_wren = 1'b0;
    host.user_w_write_32_data = '0;
    host.user_w_write_32_open = 1'b0;
    host.user_r_read_32_rden  = 1'b0;
    host.user_r_read_32_open  = 1'b0;
    ph = PH_IDLE;
    m_data = '0;
    m_sum = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge bus_clk);
    #1;

    // Basic three-word session.
    do_reset();
    chk_eq("rst_full", host.user_w_write_32_full, 1'b1);
    chk_eq("rst_empty", host.user_r_read_32_empty, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b1, i, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_eq("d3_w1", host.user_r_read_32_data, 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_eq("d3_w2", host.user_r_read_32_data, 32'h2);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_eq("d3_w3", host.user_r_read_32_data, 32'h3);
    finish_session(100, 0);

    // Overfill: fifth word dropped, overflow sticky.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + i, 1'b0, 1'b1, 1'b1);
    chk_eq("of_full", host.user_w_write_32_full, 1'b1);
    step(1'b1, 32'h99, 1'b0, 1'b1, 1'b1);
    chk_eq("of_ovf", overflow, 1'b1);
    chk_eq("of_lvl", fifo_level, 4);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      chk_eq("of_rd", host.user_r_read_32_data, 32'h10 + i);
    end
    finish_session(100, 0);

    // Simultaneous write and read at level 0.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
    chk_eq("sim_lvl", fifo_level, 1);
    chk_eq("sim_data", host.user_r_read_32_data, 32'h0);
    finish_session(100, 0);

    // Wrapping sum trailer (or plain two-word stream without it).
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h2, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_eq("cs_w1", host.user_r_read_32_data, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_eq("cs_w2", host.user_r_read_32_data, 32'h2);
    finish_session(100, 0);

    // Reset with words buffered discards them.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h70 + i, 1'b0, 1'b1, 1'b1);
    do_reset();
    chk_eq("mr_empty", host.user_r_read_32_empty, 1'b1);
    chk_eq("mr_lvl", fifo_level, 0);
    chk_eq("mr_full", host.user_w_write_32_full, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hA5, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_eq("mr_a5", host.user_r_read_32_data, 32'hA5);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    if (!CSUM_EN) chk_eq("mr_hold", host.user_r_read_32_data, 32'hA5);
    finish_session(100, 0);

    // Continuous streaming across pointer wrap.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b1, 32'h100 + i, 1'b1, 1'b1, 1'b1);
      chk_eq("wrap_lvl_ok", fifo_level <= DEPTH, 1'b1);
    end
    finish_session(100, 0);

    // Randomized sessions with occasional resets.
    for (int s = 0; s < 60; s++) begin
      int pw = $urandom_range(10, 100);
      int pr = $urandom_range(10, 100);
      int n  = $urandom_range(4, 40);
      if ($urandom_range(0, 4) == 0) do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < n; c++)
        step(($urandom_range(0, 99) < pw), $urandom, ($urandom_range(0, 99) < pr), 1'b1, 1'b1);
      if ($urandom_range(0, 5) == 0) begin
        do_reset();
      end else begin
        finish_session(pr, 20);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
